clut_arbiter: RTL and testbench
===============================

# clut_arbiter

Shares one synchronous-read color lookup table (1-cycle read latency, address sampled on `clk`) between several pixel requesters. Requester 0 is display scanout and has priority. Requesters 1..NUM_REQ-1 are served round-robin, with a starvation guard that forces a grant after MAX_WAIT blocked cycles. The block sits between the framebuffer readers and the CLUT instance: it drives the CLUT address and routes the returned color to the requester that issued the lookup.

## Interface
- `NUM_REQ`, 2: number of requesters; must be ≥2.
- `SIZE`, 256: CLUT entries.
- `COLOR_WIDTH`, 12: color word width.
- `MAX_WAIT`, 15: consecutive blocked cycles before a forced low-priority grant; must be ≥1.
- `ADDR_WIDTH` (localparam), $clog2(SIZE).

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester lookup request.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed indices; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_ready` out NUM_REQ: one-hot grant; a lookup transfers when `valid && ready`.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle pulse marking the response for requester i.
- `rsp_color` out COLOR_WIDTH: looked-up color, shared by all requesters.
- `clut_addr` out ADDR_WIDTH: registered address to the CLUT.
- `clut_color` in COLOR_WIDTH: CLUT read data, valid one cycle after `clut_addr`.

## Operation
- Each cycle at most one requester is granted. `req_ready` is combinational from `req_valid` and arbiter state. Requesters must not make `req_valid` depend on `req_ready`.
- Arbitration order:
  - Forced mode (`wait_cnt == MAX_WAIT`): the round-robin winner among 1..NUM_REQ-1 wins, even if requester 0 is valid.
  - Otherwise, requester 0 wins if valid.
  - Otherwise, the round-robin winner among 1..NUM_REQ-1 wins.
  - With no valid request, `req_ready` is all zero.
- Round-robin pointer `rr_ptr` ranges over 1..NUM_REQ-1 and resets to 1. The search starts at `rr_ptr`. After a grant to requester k≥1, `rr_ptr` becomes k+1, wrapping from NUM_REQ-1 to 1. The pointer is unchanged on a requester-0 grant or when idle.
- `wait_cnt` is 0..MAX_WAIT and saturates at MAX_WAIT:
  - It increments in each cycle where some requester ≥1 is valid and not granted.
  - It clears on any grant to a requester ≥1.
  - It holds when no requester ≥1 is valid.
- On a grant to requester g:
  - `clut_addr` loads `req_addr[g]`.
  - Stage-1 id register loads onehot(g), and stage 2 follows one cycle later.
- `rsp_valid` = stage-2 id. `rsp_color` = `clut_color`, passed through combinationally.
- Responses are never back-pressured; requesters must sink `rsp_valid` pulses unconditionally.
- When idle, `clut_addr` holds its last value and stage 1 loads zero.

## Timing
- Accept at edge T (valid && ready high in cycle T-1 → sampled at T).
  - `clut_addr` is valid in cycle T.
  - The CLUT registers at edge T+1.
  - `rsp_valid`/`rsp_color` are valid in cycle T+1, i.e. 2 cycles after the request cycle.
- Throughput: one lookup per cycle, with back-to-back grants to any mix of requesters. Responses return in grant order.
- Reset values (asynchronous):
  - `clut_addr` = 0, both id stages = 0, so `rsp_valid` = 0.
  - `rr_ptr` = 1, `wait_cnt` = 0.
  - `req_ready` = 0 while `rst_n` is low, because the grant is gated by reset.
- Reset asserted mid-operation drops in-flight lookups: no `rsp_valid` is emitted for them after release.
- The first grant is possible in the first cycle with `rst_n` high.
- Simultaneous valid on all requesters: requester 0 is granted MAX_WAIT consecutive times, then requester `rr_ptr` once, and the pattern repeats.

## Structure
- `clut_pkg` holds shared typedefs, so the CLUT and its clients use identical types:
  - `clut_addr_t` (logic [ADDR_WIDTH-1:0]) and `clut_color_t` for the default SIZE/COLOR_WIDTH.
  - Default constants `CLUT_SIZE`, `CLUT_COLOR_WIDTH`.
- Sub-module `rr_arbiter` (parameter N): round-robin pick with pointer update among requesters 1..NUM_REQ-1. It outputs a one-hot grant and a `any_grant` flag.
- Priority, starvation counter and the response pipeline stay in `clut_arbiter`.

## Test plan
- Reset check: `rst_n` low with all `req_valid` high → `req_ready` = 0, `rsp_valid` = 0, `clut_addr` = 0. After release, requester 0 is granted in the first cycle.
- Single lookup: only requester 1 valid with addr 0x05, CLUT entry 5 = 0xABC → `rsp_valid` = 2'b10 and `rsp_color` = 0xABC exactly 2 cycles after the request cycle.
- Round-robin: NUM_REQ=4, requesters 1–3 continuously valid, requester 0 idle → grant sequence 1,2,3,1,2,3, responses in the same order with matching colors.
- Starvation guard: MAX_WAIT=3, all requesters valid continuously → grant pattern 0,0,0,1,0,0,0,2,… and `wait_cnt` clears after each low-priority grant.
- Streaming: requester 0 issues addresses 0..255 back-to-back → 256 consecutive `rsp_valid` pulses with colors in address order, and no gaps.
- Reset mid-flight: assert `rst_n` low one cycle after a grant → no `rsp_valid` after release. `rr_ptr` is back at 1, shown by requester 1 winning first among 1..3.

Source files
------------

// File: rtl/clut_pkg.sv
// -----------------------------------------------------------------------------
// clut_pkg
// Shared types and constants for the color lookup table and its clients.
// The CLUT instance and every requester use the same address and color
// types, so their widths cannot drift apart.
//   CLUT_SIZE        : default number of CLUT entries
//   CLUT_COLOR_WIDTH : default color word width
//   clut_addr_t      : CLUT index type for the default size
//   clut_color_t     : color word type for the default width
//   rr_next()        : round-robin successor over requesters 1..n-1
// -----------------------------------------------------------------------------
package clut_pkg;

    localparam int CLUT_SIZE        = 256;
    localparam int CLUT_COLOR_WIDTH = 12;
    localparam int CLUT_ADDR_WIDTH  = $clog2(CLUT_SIZE);

    typedef logic [CLUT_ADDR_WIDTH-1:0]  clut_addr_t;
    typedef logic [CLUT_COLOR_WIDTH-1:0] clut_color_t;

    // Requester 0 is never part of the rotation, so the pointer wraps from
    // n-1 back to 1 rather than to 0.
    function automatic int rr_next(input int k, input int n);
        return (k >= n - 1) ? 1 : k + 1;
    endfunction

endpackage

// File: rtl/clut_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin pick among requesters 1..N-1. Bit 0 of the request vector is
// ignored and bit 0 of the grant is always zero; requester 0 is handled by
// the priority logic in the parent.
//   clk       : clock
//   rst_n     : asynchronous active-low reset (pointer returns to 1)
//   valid     : per-requester request vector (N bits)
//   advance   : the round-robin winner was actually granted this cycle
//   grant     : one-hot round-robin winner (zero when nothing is valid)
//   any_grant : some requester in 1..N-1 is valid
// -----------------------------------------------------------------------------
module rr_arbiter
    import clut_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] valid,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         any_grant
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Search starts at the pointer and walks the N-1 low-priority slots,
    // wrapping from N-1 to 1. The first valid slot wins.
    always_comb begin : search
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N - 1; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= N) begin
                idx = idx - (N - 1);
            end
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        any_grant = found;
    end

    // Pointer moves just past the winner, only when the parent actually
    // handed the grant to the round-robin side.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int k = 1; k < N; k++) begin
                if (grant[k]) begin
                    ptr_d = PW'(rr_next(k, N));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PW'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/clut_arbiter.sv
// -----------------------------------------------------------------------------
// clut_arbiter
// Shares one synchronous-read CLUT between NUM_REQ pixel requesters.
// Requester 0 (scanout) has priority; requesters 1..NUM_REQ-1 rotate
// round-robin, and a starvation counter forces a low-priority grant after
// MAX_WAIT blocked cycles. The returned color is tagged with a two-stage
// one-hot id pipeline so each response pulses only its own rsp_valid bit.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester lookup request
//   req_addr   : packed indices, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready  : one-hot grant (combinational)
//   rsp_valid  : one-hot response pulse, two cycles after the request cycle
//   rsp_color  : CLUT read data, passed straight through
//   clut_addr  : registered CLUT address
//   clut_color : CLUT read data, one cycle after clut_addr
// -----------------------------------------------------------------------------
module clut_arbiter
    import clut_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int SIZE        = CLUT_SIZE,
    parameter int COLOR_WIDTH = CLUT_COLOR_WIDTH,
    parameter int MAX_WAIT    = 15
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*$clog2(SIZE)-1:0]    req_addr,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [COLOR_WIDTH-1:0]             rsp_color,
    output logic [$clog2(SIZE)-1:0]            clut_addr,
    input  logic [COLOR_WIDTH-1:0]             clut_color
);

    localparam int ADDR_WIDTH = $clog2(SIZE);
    localparam int WW         = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [NUM_REQ-1:0]    rr_grant;
    logic                  rr_any;
    logic                  forced;
    logic                  lo_valid;
    logic                  lo_granted;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    grant_gated;
    logic [ADDR_WIDTH-1:0] addr_terms [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_sel;

    logic [ADDR_WIDTH-1:0] clut_addr_q;
    logic [ADDR_WIDTH-1:0] clut_addr_d;
    logic [NUM_REQ-1:0]    stage1_q;
    logic [NUM_REQ-1:0]    stage2_q;
    logic [WW-1:0]         wait_q;
    logic [WW-1:0]         wait_d;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (req_valid),
        .advance  (lo_granted),
        .grant    (rr_grant),
        .any_grant(rr_any)
    );

    assign lo_valid = |req_valid[NUM_REQ-1:1];
    assign forced   = (wait_q == WAIT_MAX);

    // Forced mode overrides scanout priority; if forced but no low-priority
    // requester is valid any more, scanout still gets the slot.
    always_comb begin
        grant = '0;
        if (forced && rr_any) begin
            grant = rr_grant;
        end else if (req_valid[0]) begin
            grant[0] = 1'b1;
        end else if (rr_any) begin
            grant = rr_grant;
        end
    end

    // Gating with rst_n keeps req_ready low for the whole reset interval,
    // so no requester believes a transfer happened while state is cleared.
    assign grant_gated = grant & {NUM_REQ{rst_n}};
    assign req_ready   = grant_gated;
    assign lo_granted  = |grant_gated[NUM_REQ-1:1];

    // One-hot grant makes an AND-OR mux sufficient for the address select.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_terms[gi] = grant_gated[gi]
                                  ? req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]
                                  : '0;
        end
    endgenerate

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_sel = addr_sel | addr_terms[i];
        end
    end

    // Address holds its last value when idle.
    always_comb begin
        clut_addr_d = clut_addr_q;
        if (|grant_gated) begin
            clut_addr_d = addr_sel;
        end
    end

    // Starvation counter: cleared by any low-priority grant, counts while a
    // low-priority requester is waiting, holds when none are waiting.
    always_comb begin
        wait_d = wait_q;
        if (lo_granted) begin
            wait_d = '0;
        end else if (lo_valid && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clut_addr_q <= '0;
            stage1_q    <= '0;
            stage2_q    <= '0;
            wait_q      <= '0;
        end else begin
            clut_addr_q <= clut_addr_d;
            stage1_q    <= grant_gated;
            stage2_q    <= stage1_q;
            wait_q      <= wait_d;
        end
    end

    assign clut_addr = clut_addr_q;
    assign rsp_valid = stage2_q;
    assign rsp_color = clut_color;

endmodule

// File: tb/tb_clut_arbiter.sv
module tb_clut_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int CW = 12;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [CW-1:0]   rsp_color;
    logic [AW-1:0]   clut_addr;
    logic [CW-1:0]   clut_color;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [NR-1:0] exp_g [0:299];
    logic [AW-1:0] exp_a [0:299];

    clut_arbiter #(
        .NUM_REQ    (NR),
        .SIZE       (256),
        .COLOR_WIDTH(CW),
        .MAX_WAIT   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_color (rsp_color),
        .clut_addr (clut_addr),
        .clut_color(clut_color)
    );

    // CLUT contents; entry 5 holds 0xABC.
    function automatic logic [CW-1:0] tb_color(input logic [AW-1:0] a);
        if (a == 8'h05) return 12'hABC;
        return {a[3:0], a} ^ 12'h35A;
    endfunction

    always @(posedge clk) clut_color <= tb_color(clut_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        req_addr  = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_addr  = {8'h44, 8'h33, 8'h22, 8'h11};
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", req_ready);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
        else pass_cnt++;
        chk_cnt++;
        if (clut_addr !== 8'h00) $display("FAIL reset_clut_addr: got %h expected 00", clut_addr);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++;
        if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk_cnt++;
        if (clut_addr !== 8'h11) $display("FAIL reset_first_addr: got %h expected 11", clut_addr);
        else pass_cnt++;
        $display("test_reset done: %0d/%0d", pass_cnt, chk_cnt);
    endtask

    task automatic test_single();
        exp_g[0] = 4'b0010;
        exp_a[0] = 8'h05;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 4'b0010 : 4'b0000;
            req_addr  = (c == 0) ? {8'h00, 8'h00, 8'h05, 8'h00} : '0;
            #1;
            chk_cnt++;
            if (req_ready !== ((c == 0) ? 4'b0010 : 4'b0000))
                $display("FAIL single_ready c=%0d: got %b", c, req_ready);
            else pass_cnt++;
            if (c == 1) begin
                chk_cnt++;
                if (clut_addr !== 8'h05) $display("FAIL single_clut_addr: got %h expected 05", clut_addr);
                else pass_cnt++;
            end
            chk_cnt++;
            if (rsp_valid !== ((c == 2) ? 4'b0010 : 4'b0000))
                $display("FAIL single_rsp_valid c=%0d: got %b", c, rsp_valid);
            else pass_cnt++;
            if (c == 2) begin
                chk_cnt++;
                if (rsp_color !== 12'hABC) $display("FAIL single_rsp_color: got %h expected abc", rsp_color);
                else pass_cnt++;
            end
        end
        $display("test_single done: %0d/%0d", pass_cnt, chk_cnt);
    endtask

    task automatic test_round_robin();
        int n;
        logic [NR-1:0] erv;
        n = 6;
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            if (c < n) begin
                req_valid = 4'b1110;
                for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 8'(16 * i + c);
                exp_g[c] = 4'b0001 << (1 + c % 3);
                exp_a[c] = 8'(16 * (1 + c % 3) + c);
            end else begin
                req_valid = '0;
                exp_g[c]  = '0;
            end
            #1;
            chk_cnt++;
            if (req_ready !== exp_g[c]) $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, exp_g[c]);
            else pass_cnt++;
            erv = (c >= 2) ? exp_g[c-2] : '0;
            chk_cnt++;
            if (rsp_valid !== erv) $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, erv);
            else pass_cnt++;
            if (erv != '0) begin
                chk_cnt++;
                if (rsp_color !== tb_color(exp_a[c-2]))
                    $display("FAIL rr_rsp_color c=%0d: got %h expected %h", c, rsp_color, tb_color(exp_a[c-2]));
                else pass_cnt++;
            end
        end
        $display("test_round_robin done: %0d/%0d", pass_cnt, chk_cnt);
    endtask

    task automatic test_starvation();
        int n;
        int g;
        logic [NR-1:0] erv;
        n = 16;
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            if (c < n) begin
                req_valid = 4'b1111;
                for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 8'(32 * i + c);
                g = (c % 4 == 3) ? 1 + (c / 4) % 3 : 0;
                exp_g[c] = 4'b0001 << g;
                exp_a[c] = 8'(32 * g + c);
                chk_cnt++;
                if (dut.wait_q !== 2'(c % 4))
                    $display("FAIL starve_wait_cnt c=%0d: got %0d expected %0d", c, dut.wait_q, c % 4);
                else pass_cnt++;
            end else begin
                req_valid = '0;
                exp_g[c]  = '0;
            end
            #1;
            chk_cnt++;
            if (req_ready !== exp_g[c]) $display("FAIL starve_grant c=%0d: got %b expected %b", c, req_ready, exp_g[c]);
            else pass_cnt++;
            erv = (c >= 2) ? exp_g[c-2] : '0;
            chk_cnt++;
            if (rsp_valid !== erv) $display("FAIL starve_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, erv);
            else pass_cnt++;
            if (erv != '0) begin
                chk_cnt++;
                if (rsp_color !== tb_color(exp_a[c-2]))
                    $display("FAIL starve_rsp_color c=%0d: got %h expected %h", c, rsp_color, tb_color(exp_a[c-2]));
                else pass_cnt++;
            end
        end
        $display("test_starvation done: %0d/%0d", pass_cnt, chk_cnt);
    endtask

    task automatic test_streaming();
        int n;
        logic [NR-1:0] erv;
        n = 256;
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clk);
            if (c < n) begin
                req_valid = 4'b0001;
                req_addr  = '0;
                req_addr[AW-1:0] = 8'(c);
                exp_g[c] = 4'b0001;
                exp_a[c] = 8'(c);
            end else begin
                req_valid = '0;
                exp_g[c]  = '0;
            end
            #1;
            chk_cnt++;
            if (req_ready !== exp_g[c]) $display("FAIL stream_grant c=%0d: got %b expected %b", c, req_ready, exp_g[c]);
            else pass_cnt++;
            erv = (c >= 2) ? exp_g[c-2] : '0;
            chk_cnt++;
            if (rsp_valid !== erv) $display("FAIL stream_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, erv);
            else pass_cnt++;
            if (erv != '0) begin
                chk_cnt++;
                if (rsp_color !== tb_color(exp_a[c-2]))
                    $display("FAIL stream_rsp_color c=%0d: got %h expected %h", c, rsp_color, tb_color(exp_a[c-2]));
                else pass_cnt++;
            end
        end
        $display("test_streaming done: %0d/%0d", pass_cnt, chk_cnt);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        req_valid = 4'b0010;
        req_addr  = {8'h00, 8'h00, 8'h07, 8'h00};
        #1;
        chk_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL mid_grant: got %b expected 0010", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk_cnt++;
        if (clut_addr !== 8'h00) $display("FAIL mid_clut_addr: got %h expected 00", clut_addr);
        else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk_cnt++;
            if (rsp_valid !== 4'b0000) $display("FAIL mid_rsp_in_reset c=%0d: got %b", c, rsp_valid);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk_cnt++;
            if (rsp_valid !== 4'b0000) $display("FAIL mid_rsp_after c=%0d: got %b", c, rsp_valid);
            else pass_cnt++;
        end
        @(negedge clk);
        req_valid = 4'b1110;
        #1;
        chk_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL mid_rr_ptr: got %b expected 0010", req_ready);
        else pass_cnt++;
        @(negedge clk);
        req_valid = '0;
        $display("test_reset_midflight done: %0d/%0d", pass_cnt, chk_cnt);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        test_reset();
        do_reset();
        test_single();
        do_reset();
        test_round_robin();
        do_reset();
        test_starvation();
        do_reset();
        test_streaming();
        do_reset();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
